ex_muldiv_seq: RTL and testbench
================================

// Module: ex_muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for RV64M multiply/divide. It sits beside the single-cycle Ex stage.
//  Decode raises StartIn for OP/OP-32 instructions with Funct7=0000001. The block runs an
//  iterative radix-2 shift-add / restoring-divide loop. BusyOut stalls the pipeline; a
//  DoneOut pulse delivers the result and the Rd tag to write-back.
// PARAMETERS
//  XLEN     64   operand/result width; also the iteration count
//  CNT_W    6    iteration counter width, clog2(XLEN)
// PORTS
//  Clk               in   1      clock, rising edge
//  Rst_n             in   1      asynchronous active-low reset
//  StartIn           in   1      request; sampled only in IDLE
//  FlushIn           in   1      abort current operation (branch/trap flush)
//  Funct3In          in   3      000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  WordIn            in   1      1 = OP-32 (*W) form: use low 32 bits, sign-extend result
//  Rs1ReadDataIn     in   XLEN   operand A
//  Rs2ReadDataIn     in   XLEN   operand B
//  RdAddrIn          in   5      destination tag (`RegFileAddr)
//  BusyOut           out  1      1 from the cycle after accept until DONE; pipeline stalls
//  DoneOut           out  1      1-cycle result-valid pulse
//  RdWriteDataOut    out  XLEN   result, valid while DoneOut
//  RdAddrOut         out  5      captured tag, valid while DoneOut
//  RdWriteEnableOut  out  1      equals DoneOut
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, counter and operand registers are 0.
//  FSM: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: StartIn=1 and FlushIn=0 at edge T captures operands, Funct3, WordIn and RdAddr.
//   PREP (T+1): take absolute values for signed ops; W forms sign- or zero-extend the low 32 bits.
//     Special cases jump straight to DONE:
//       divide by zero: quotient = all-ones; remainder = dividend.
//       signed overflow (MIN / -1): quotient = MIN; remainder = 0.
//   CALC (T+2..T+65): counter runs XLEN-1 down to 0; one shift-add or shift-subtract step per cycle.
//   FIX (T+66): apply sign correction. Quotient sign = sA^sB. Remainder sign = sA.
//     MULH* selects the high half of the 2*XLEN product; MUL selects the low half.
//     MULHSU treats rs1 as signed and rs2 as unsigned.
//   DONE: T+67 normally, T+2 for special cases. DoneOut=1 for exactly one cycle, then IDLE.
//  Latency: 67 cycles for XLEN=64. *W forms use the same count.
//  W result: {{32{r[31]}}, r[31:0]}. The MUL low half is taken mod 2^XLEN.
//  BusyOut = (state != IDLE) && (state != DONE).
//  StartIn while not IDLE: ignored; the decode stall guarantees it is held.
//  FlushIn in any state: next state IDLE; no DoneOut; registered result is not updated.
//  FlushIn and StartIn in the same IDLE cycle: flush wins; the request is not accepted.
//  StartIn in the DONE cycle: ignored; it is accepted one cycle later in IDLE.
//  Rst_n low mid-operation: immediate return to the reset values; no partial DoneOut.
// STRUCTURE
//  Shared package (defines.v):
//    `DataBus, `RegFileAddr
//    MD funct3 codes `MD_MUL..`MD_REMU
//    FSM state encodings `MDS_IDLE..`MDS_DONE (3-bit)
//  Sub-module ex_muldiv_step: combinational single-iteration datapath.
//    Inputs: partial accumulator, shift register, divisor/multiplicand, mode.
//    Outputs: next accumulator and next shift register.
//  The FSM, counter, sign bookkeeping and result mux stay in ex_muldiv_seq.
// TESTING
//  MUL 7 * -3, Start at T -> DoneOut at T+67, data 0xFFFF_FFFF_FFFF_FFEB, RdAddrOut = captured tag.
//  MULHU all-ones * all-ones -> 0xFFFF_FFFF_FFFF_FFFE. MULH -1 * -1 -> 0.
//  DIV 5 / 0 -> DoneOut at T+2, 0xFFFF_FFFF_FFFF_FFFF.
//    REMU 5 / 0 -> 5.
//    DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
//    REM of the same operands -> 0.
//  DIVW rs1 = 0x1234_5678_8000_0000, rs2 = 2 -> 0xFFFF_FFFF_C000_0000.
//    REMW -7 / 2 -> 0xFFFF_FFFF_FFFF_FFFF.
//  Flush at T+30 -> BusyOut=0 at T+31 and no DoneOut ever.
//    New Start at T+31 completes normally at T+98.
//  Start+Flush together -> not accepted.
//    Start pulses while Busy -> ignored; exactly one DoneOut per accepted request.

Source files
------------

// File: rtl/ex_muldiv_seq_pkg.sv
// rtl/ex_muldiv_seq_pkg.sv - shared types, widths and helpers for the RV64M multiply/divide sequencer
package ex_muldiv_seq_pkg;

   localparam int XLEN  = 64;
   localparam int CNT_W = 6;
   localparam int WLEN  = 32;

   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [2:0] {
      MDS_IDLE = 3'd0,
      MDS_PREP = 3'd1,
      MDS_CALC = 3'd2,
      MDS_FIX  = 3'd3,
      MDS_DONE = 3'd4
   } md_state_e;

   function automatic logic op_a_signed(input logic [2:0] f3);
      return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
   endfunction

   function automatic logic op_b_signed(input logic [2:0] f3);
      return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
   endfunction

   // *W forms operate on the low word, widened according to operand signedness
   function automatic logic [XLEN-1:0] ext_operand(input logic [XLEN-1:0] v, input logic word,
                                                   input logic sgn);
      if (!word)
         return v;
      return {{(XLEN-WLEN){sgn & v[WLEN-1]}}, v[WLEN-1:0]};
   endfunction

   function automatic logic [XLEN-1:0] wfix(input logic word, input logic [XLEN-1:0] r);
      return word ? {{(XLEN-WLEN){r[WLEN-1]}}, r[WLEN-1:0]} : r;
   endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// rtl/ex_muldiv_step.sv - one radix-2 shift-add (multiply) or restoring-subtract (divide) iteration
module ex_muldiv_step
   import ex_muldiv_seq_pkg::*;
(
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] shreg_i,
   input  logic [XLEN-1:0] operand_i,
   input  logic            is_div_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] shreg_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      sum     = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, operand_i} : {(XLEN+1){1'b0}});
      shifted = {acc_i, shreg_i[XLEN-1]};
      diff    = shifted - {1'b0, operand_i};
      if (is_div_i) begin
         // diff[XLEN] is the borrow: partial remainder smaller than divisor
         if (diff[XLEN]) begin
            acc_o   = shifted[XLEN-1:0];
            shreg_o = {shreg_i[XLEN-2:0], 1'b0};
         end else begin
            acc_o   = diff[XLEN-1:0];
            shreg_o = {shreg_i[XLEN-2:0], 1'b1};
         end
      end else begin
         acc_o   = sum[XLEN:1];
         shreg_o = {sum[0], shreg_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - multi-cycle RV64M multiply/divide sequencer beside the Ex stage
module ex_muldiv_seq
   import ex_muldiv_seq_pkg::*;
(
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            StartIn,
   input  logic            FlushIn,
   input  logic [2:0]      Funct3In,
   input  logic            WordIn,
   input  logic [XLEN-1:0] Rs1ReadDataIn,
   input  logic [XLEN-1:0] Rs2ReadDataIn,
   input  logic [4:0]      RdAddrIn,
   output logic            BusyOut,
   output logic            DoneOut,
   output logic [XLEN-1:0] RdWriteDataOut,
   output logic [4:0]      RdAddrOut,
   output logic            RdWriteEnableOut
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  acc_q, acc_d;
   logic [XLEN-1:0]  shreg_q, shreg_d;
   logic [XLEN-1:0]  opnd_q, opnd_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic [2:0]       f3_q, f3_d;
   logic             word_q, word_d;
   logic [4:0]       rd_q, rd_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;

   logic              a_signed, b_signed;
   logic [XLEN-1:0]   a_ext, b_ext;
   logic              neg_a, neg_b;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   special_res;
   logic [XLEN-1:0]   step_acc, step_shreg;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot, rem, fix_res;

   ex_muldiv_step u_step (
      .acc_i     (acc_q),
      .shreg_i   (shreg_q),
      .operand_i (opnd_q),
      .is_div_i  (f3_q[2]),
      .acc_o     (step_acc),
      .shreg_o   (step_shreg)
   );

   // Raw operands sit in shreg_q/opnd_q during PREP and are replaced by magnitudes
   always_comb begin
      a_signed = op_a_signed(f3_q);
      b_signed = op_b_signed(f3_q);
      a_ext    = ext_operand(shreg_q, word_q, a_signed);
      b_ext    = ext_operand(opnd_q, word_q, b_signed);
      neg_a    = a_signed & a_ext[XLEN-1];
      neg_b    = b_signed & b_ext[XLEN-1];
      div_zero = f3_q[2] & (b_ext == '0);
      div_ovf  = f3_q[2] & b_signed & (a_ext == XMIN) & (b_ext == '1);
      special  = div_zero | div_ovf;
      if (div_zero)
         special_res = f3_q[1] ? a_ext : '1;
      else
         special_res = f3_q[1] ? '0 : XMIN;
   end

   always_comb begin
      prod = {acc_q, shreg_q};
      if (sa_q ^ sb_q)
         prod = -prod;
      quot = (sa_q ^ sb_q) ? -shreg_q : shreg_q;
      rem  = sa_q ? -acc_q : acc_q;
      if (f3_q[2])
         fix_res = f3_q[1] ? rem : quot;
      else
         fix_res = (f3_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         state_q <= MDS_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         MDS_IDLE: if (StartIn) state_d = MDS_PREP;
         MDS_PREP: state_d = special ? MDS_DONE : MDS_CALC;
         MDS_CALC: if (cnt_q == '0) state_d = MDS_FIX;
         MDS_FIX:  state_d = MDS_DONE;
         MDS_DONE: state_d = MDS_IDLE;
         default:  state_d = MDS_IDLE;
      endcase
      if (FlushIn)
         state_d = MDS_IDLE;
   end

   always_comb begin
      BusyOut          = (state_q != MDS_IDLE) && (state_q != MDS_DONE);
      DoneOut          = (state_q == MDS_DONE) && !FlushIn;
      RdWriteEnableOut = (state_q == MDS_DONE) && !FlushIn;
   end

   assign RdWriteDataOut = result_q;
   assign RdAddrOut      = rd_q;

   always_comb begin
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      shreg_d  = shreg_q;
      opnd_d   = opnd_q;
      result_d = result_q;
      f3_d     = f3_q;
      word_d   = word_q;
      rd_d     = rd_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      if (!FlushIn) begin
         unique case (state_q)
            MDS_IDLE: begin
               if (StartIn) begin
                  shreg_d = Rs1ReadDataIn;
                  opnd_d  = Rs2ReadDataIn;
                  f3_d    = Funct3In;
                  word_d  = WordIn;
                  rd_d    = RdAddrIn;
               end
            end
            MDS_PREP: begin
               if (special) begin
                  result_d = wfix(word_q, special_res);
               end else begin
                  acc_d   = '0;
                  shreg_d = neg_a ? -a_ext : a_ext;
                  opnd_d  = neg_b ? -b_ext : b_ext;
                  sa_d    = neg_a;
                  sb_d    = neg_b;
                  cnt_d   = CNT_W'(XLEN-1);
               end
            end
            MDS_CALC: begin
               acc_d   = step_acc;
               shreg_d = step_shreg;
               cnt_d   = cnt_q - CNT_W'(1);
            end
            MDS_FIX:  result_d = wfix(word_q, fix_res);
            default:  ;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         shreg_q  <= '0;
         opnd_q   <= '0;
         result_q <= '0;
         f3_q     <= '0;
         word_q   <= 1'b0;
         rd_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         shreg_q  <= shreg_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
         f3_q     <= f3_d;
         word_q   <= word_d;
         rd_q     <= rd_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - directed-vector bench for ex_muldiv_seq
module tb_ex_muldiv_seq;

   logic        Clk;
   logic        Rst_n;
   logic        StartIn;
   logic        FlushIn;
   logic [2:0]  Funct3In;
   logic        WordIn;
   logic [63:0] Rs1ReadDataIn;
   logic [63:0] Rs2ReadDataIn;
   logic [4:0]  RdAddrIn;
   logic        BusyOut;
   logic        DoneOut;
   logic [63:0] RdWriteDataOut;
   logic [4:0]  RdAddrOut;
   logic        RdWriteEnableOut;

   int n_vec;
   int n_err;
   int done_cnt;

   ex_muldiv_seq dut (
      .Clk              (Clk),
      .Rst_n            (Rst_n),
      .StartIn          (StartIn),
      .FlushIn          (FlushIn),
      .Funct3In         (Funct3In),
      .WordIn           (WordIn),
      .Rs1ReadDataIn    (Rs1ReadDataIn),
      .Rs2ReadDataIn    (Rs2ReadDataIn),
      .RdAddrIn         (RdAddrIn),
      .BusyOut          (BusyOut),
      .DoneOut          (DoneOut),
      .RdWriteDataOut   (RdWriteDataOut),
      .RdAddrOut        (RdAddrOut),
      .RdWriteEnableOut (RdWriteEnableOut)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial done_cnt = 0;
   always @(negedge Clk) if (DoneOut) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd);
      StartIn       = 1'b1;
      Funct3In      = f3;
      WordIn        = w;
      Rs1ReadDataIn = a;
      Rs2ReadDataIn = b;
      RdAddrIn      = rd;
   endtask

   // StartIn is high for one cycle (cycle T); returns just after the accepting edge
   task automatic start_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] rd);
      @(posedge Clk); #1;
      drive(f3, w, a, b, rd);
      @(posedge Clk); #1;
      StartIn = 1'b0;
   endtask

   // lat = k where DoneOut is first seen in cycle T+k; -1 if it never comes
   task automatic wait_done(output int lat, output logic busy1);
      lat   = -1;
      busy1 = 1'b0;
      for (int k = 1; k <= 150; k++) begin
         @(negedge Clk);
         if (k == 1) busy1 = BusyOut;
         if (DoneOut) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input logic [63:0] exp, input int exp_lat);
      int   lat;
      logic busy1;
      start_op(f3, w, a, b, rd);
      wait_done(lat, busy1);
      check({tag, "_busy"}, 64'(busy1), 64'd1);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_data"}, RdWriteDataOut, exp);
      check({tag, "_rd"}, 64'(RdAddrOut), 64'(rd));
      check({tag, "_we"}, 64'(RdWriteEnableOut), 64'd1);
      @(negedge Clk);
      check({tag, "_done_pulse"}, 64'(DoneOut), 64'd0);
   endtask

   initial begin
      int   d0;
      int   lat;
      logic busy1;
      n_vec = 0;
      n_err = 0;
      Rst_n = 1'b0;
      StartIn = 1'b0;
      FlushIn = 1'b0;
      Funct3In = 3'b000;
      WordIn = 1'b0;
      Rs1ReadDataIn = '0;
      Rs2ReadDataIn = '0;
      RdAddrIn = '0;
      #12;
      check("rst_busy", 64'(BusyOut), 64'd0);
      check("rst_done", 64'(DoneOut), 64'd0);
      check("rst_data", RdWriteDataOut, 64'd0);
      check("rst_rd", 64'(RdAddrOut), 64'd0);
      @(posedge Clk); #1;
      Rst_n = 1'b1;

      run_op("mul", 3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 64'hFFFF_FFFF_FFFF_FFEB, 67);
      run_op("mulhu", 3'b011, 1'b0, '1, '1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 67);
      run_op("mulh", 3'b001, 1'b0, '1, '1, 5'd6, 64'd0, 67);
      run_op("mulhsu", 3'b010, 1'b0, '1, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 67);
      run_op("div0", 3'b100, 1'b0, 64'd5, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 2);
      run_op("remu0", 3'b111, 1'b0, 64'd5, 64'd0, 5'd12, 64'd5, 2);
      run_op("divovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd13, 64'h8000_0000_0000_0000, 2);
      run_op("removf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd14, 64'd0, 2);
      run_op("divw", 3'b100, 1'b1, 64'h1234_5678_8000_0000, 64'd2, 5'd15, 64'hFFFF_FFFF_C000_0000, 67);
      run_op("remw", 3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 67);
      run_op("divu", 3'b101, 1'b0, '1, 64'd16, 5'd17, 64'h0FFF_FFFF_FFFF_FFFF, 67);
      run_op("mulw", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd18, 64'hFFFF_FFFF_FFFF_FFFE, 67);
      run_op("div", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd19, 64'hFFFF_FFFF_FFFF_FFF2, 67);
      run_op("rem", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd20, 64'hFFFF_FFFF_FFFF_FFFE, 67);

      // flush in cycle T+30, restart in cycle T+31
      d0 = done_cnt;
      start_op(3'b101, 1'b0, 64'd100, 64'd7, 5'd7);
      repeat (29) @(posedge Clk);
      #1 FlushIn = 1'b1;
      @(posedge Clk); #1;
      FlushIn = 1'b0;
      drive(3'b000, 1'b0, 64'd3, 64'd5, 5'd11);
      @(negedge Clk);
      check("flush_busy", 64'(BusyOut), 64'd0);
      check("flush_keep", RdWriteDataOut, 64'hFFFF_FFFF_FFFF_FFFE);
      @(posedge Clk); #1;
      StartIn = 1'b0;
      wait_done(lat, busy1);
      check("restart_lat", 64'(lat), 64'd67);
      check("restart_data", RdWriteDataOut, 64'd15);
      check("restart_rd", 64'(RdAddrOut), 64'd11);
      @(posedge Clk); #1;
      check("flush_dones", 64'(done_cnt - d0), 64'd1);

      // start and flush together
      @(posedge Clk); #1;
      drive(3'b000, 1'b0, 64'd2, 64'd2, 5'd21);
      FlushIn = 1'b1;
      @(posedge Clk); #1;
      StartIn = 1'b0;
      FlushIn = 1'b0;
      @(negedge Clk);
      check("sf_busy", 64'(BusyOut), 64'd0);
      d0 = done_cnt;
      repeat (80) @(posedge Clk);
      #1 check("sf_dones", 64'(done_cnt - d0), 64'd0);

      // start pulses while busy are ignored
      d0 = done_cnt;
      start_op(3'b101, 1'b0, 64'd100, 64'd7, 5'd5);
      repeat (9) @(posedge Clk);
      #1 drive(3'b000, 1'b0, 64'd3, 64'd3, 5'd9);
      @(posedge Clk); #1;
      StartIn = 1'b0;
      repeat (10) @(posedge Clk);
      #1 drive(3'b011, 1'b0, 64'd9, 64'd9, 5'd22);
      @(posedge Clk); #1;
      StartIn = 1'b0;
      wait_done(lat, busy1);
      check("busy_ign_data", RdWriteDataOut, 64'd14);
      check("busy_ign_rd", 64'(RdAddrOut), 64'd5);
      repeat (80) @(posedge Clk);
      #1 check("busy_ign_dones", 64'(done_cnt - d0), 64'd1);

      // asynchronous reset mid-operation
      start_op(3'b011, 1'b0, '1, '1, 5'd2);
      repeat (20) @(posedge Clk);
      #3 Rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 64'(BusyOut), 64'd0);
      check("mid_rst_data", RdWriteDataOut, 64'd0);
      check("mid_rst_rd", 64'(RdAddrOut), 64'd0);
      @(posedge Clk); #1;
      Rst_n = 1'b1;
      d0 = done_cnt;
      repeat (80) @(posedge Clk);
      #1 check("mid_rst_dones", 64'(done_cnt - d0), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
